glb_block_sink: RTL

Synthesizable global-buffer-side receiver for block-mode streams produced by a fiber-access read scanner (`read_scanner_block_rd_out`). It accepts length-prefixed blocks over a 17-bit valid/ready link and writes each payload word into a GLB-style memory write port at a configurable base/stride address. It asserts `done` after a configured number of blocks. It replaces the behavioural bench reader with hardware that sits between a tile and the GLB bank.

---
 rtl/glb_block_sink_pkg.sv | 9 +
 rtl/glb_block_sink_addr_gen.sv | 36 +++
 rtl/glb_block_sink.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/glb_block_sink_pkg.sv
// rtl/glb_block_sink_pkg.sv - shared types and constants for the block-mode GLB sink
package glb_block_sink_pkg;

  typedef enum logic [1:0] {HDR, BODY, DONE} state_t;

  localparam int          CTRL_BIT   = 16;
  localparam logic [16:0] DONE_TOKEN = 17'h10100;

endpackage

// File: rtl/glb_block_sink_addr_gen.sv
// rtl/glb_block_sink_addr_gen.sv - base + accumulated block offset + word index address generator
module glb_block_sink_addr_gen
  import glb_block_sink_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clk_en,
  input  logic                  i_flush,
  input  logic                  i_blk_done,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [ADDR_WIDTH-1:0] i_stride,
  input  logic [CNT_WIDTH-1:0]  i_word_cnt,
  output logic [ADDR_WIDTH-1:0] o_addr
);

  // Tracks blk_count*stride by accumulation so no multiplier is needed.
  logic [ADDR_WIDTH-1:0] r_blk_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_off <= '0;
    end else if (i_clk_en) begin
      if (i_flush) begin
        r_blk_off <= '0;
      end else if (i_blk_done) begin
        r_blk_off <= r_blk_off + i_stride;
      end
    end
  end

  assign o_addr = i_base + r_blk_off + ADDR_WIDTH'(i_word_cnt);

endmodule

// File: rtl/glb_block_sink.sv
// rtl/glb_block_sink.sv - length-prefixed block stream to GLB write port; GLB_BLOCK_SINK_CHECK_EN enables control-word dropping
module glb_block_sink
  import glb_block_sink_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic [DATA_WIDTH:0]   stream_in,
  input  logic                  stream_in_valid,
  output logic                  stream_in_ready,
  input  logic [ADDR_WIDTH-1:0] addr_base,
  input  logic [ADDR_WIDTH-1:0] addr_stride,
  input  logic [CNT_WIDTH-1:0]  tx_num,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wen,
  output logic [CNT_WIDTH-1:0]  blk_count,
  output logic                  done,
  output logic                  err
);

  state_t                r_state;
  logic                  r_live;
  logic [DATA_WIDTH-1:0] r_len;
  logic [CNT_WIDTH-1:0]  r_word_cnt;
  logic [CNT_WIDTH-1:0]  r_blk_count;
  logic                  r_err;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;

  logic                  w_xfer;
  logic                  w_ctrl;
  logic                  w_data_xfer;
  logic                  w_last;
  logic                  w_blk_done;
  logic [DATA_WIDTH-1:0] w_payload;
  logic [CNT_WIDTH-1:0]  w_blk_next;
  logic [ADDR_WIDTH-1:0] w_addr;

`ifdef GLB_BLOCK_SINK_CHECK_EN
  assign w_ctrl = stream_in[CTRL_BIT];
`else
  logic w_unused_ctrl;
  assign w_unused_ctrl = stream_in[CTRL_BIT];
  assign w_ctrl        = 1'b0;
`endif

  // r_live keeps ready low while reset is held; tx_num==0 never opens the link.
  assign stream_in_ready = r_live & (r_state != DONE) & (r_blk_count != tx_num);
  assign w_xfer          = stream_in_valid & stream_in_ready & clk_en;
  assign w_data_xfer     = w_xfer & ~w_ctrl;
  assign w_payload       = stream_in[DATA_WIDTH-1:0];
  assign w_last          = (r_word_cnt == CNT_WIDTH'(r_len - DATA_WIDTH'(1)));
  assign w_blk_next      = r_blk_count + CNT_WIDTH'(1);
  assign w_blk_done      = w_data_xfer &
                           (((r_state == HDR) & (w_payload == '0)) |
                            ((r_state == BODY) & w_last));

  glb_block_sink_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clk_en   (clk_en),
    .i_flush    (flush),
    .i_blk_done (w_blk_done),
    .i_base     (addr_base),
    .i_stride   (addr_stride),
    .i_word_cnt (r_word_cnt),
    .o_addr     (w_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= HDR;
      r_live      <= 1'b0;
      r_len       <= '0;
      r_word_cnt  <= '0;
      r_blk_count <= '0;
      r_err       <= 1'b0;
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
    end else begin
      r_live <= 1'b1;
      if (!clk_en) begin
        r_wen <= 1'b0;
      end else if (flush) begin
        r_state     <= HDR;
        r_len       <= '0;
        r_word_cnt  <= '0;
        r_blk_count <= '0;
        r_err       <= 1'b0;
        r_wen       <= 1'b0;
      end else begin
        r_wen <= 1'b0;
        if (w_xfer && w_ctrl) begin
          r_err <= 1'b1;
        end
        case (r_state)
          HDR: begin
            if (r_blk_count == tx_num) begin
              r_state <= DONE;
            end else if (w_data_xfer) begin
              r_len      <= w_payload;
              r_word_cnt <= '0;
              if (w_payload == '0) begin
                r_blk_count <= w_blk_next;
                r_state     <= (w_blk_next == tx_num) ? DONE : HDR;
              end else begin
                r_state <= BODY;
              end
            end
          end
          BODY: begin
            if (w_data_xfer) begin
              r_wen      <= 1'b1;
              r_addr     <= w_addr;
              r_data     <= w_payload;
              r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
              if (w_last) begin
                r_blk_count <= w_blk_next;
                r_state     <= (w_blk_next == tx_num) ? DONE : HDR;
              end
            end
          end
          default: r_state <= DONE;
        endcase
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_data  = r_data;
  assign mem_wen   = r_wen;
  assign blk_count = r_blk_count;
  assign done      = (r_state == DONE);
  assign err       = r_err;

endmodule
